// File: rtl/ahb_bridge_sink_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_bridge_sink_ctrl
//  Description : Sink-side AHB2AHB bridge controller. Pops request packets,
//                issues registered valid/ready commands to the sink master,
//                returns read data or timeout errors as response packets, and
//                runs the sleep/drain/wake handshake with the source side.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_bridge_sink_ctrl #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 3,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int REQ_W           = ADDR_WIDTH + DATA_WIDTH + 2,
    parameter int RSP_W           = DATA_WIDTH + 2
) (
    input  logic                  i_clk_sink,
    input  logic                  i_rstn_sink,
    input  logic                  i_sink_sleep_req,
    input  logic                  i_source_sleep_status,
    input  logic [REQ_W-1:0]      i_req_packet,
    input  logic                  i_req_fifo_empty,
    output logic                  o_req_fifo_rd_en,
    input  logic                  i_rsp_fifo_full,
    input  logic                  i_rsp_fifo_empty,
    output logic                  o_rsp_fifo_wr_en,
    output logic [RSP_W-1:0]      o_rsp_packet,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic                  i_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_sink_sleep_ack,
    output logic                  o_sink_sleep_status,
    output logic [CNT_WIDTH-1:0]  o_outstanding,
    output logic                  o_overflow
);

    localparam int                   c_tmr_w    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_tmr_w-1:0]   c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_WIDTH:0]   c_max      = (CNT_WIDTH + 1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_IDLE   = 2'd2,
        ST_WAKE   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic                    rd0_wr1_q, rd0_wr1_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [CNT_WIDTH-1:0]    outstanding_q, outstanding_d;
    logic [c_tmr_w-1:0]      tmr_q, tmr_d;
    logic                    rsp_wr_en_q, rsp_wr_en_d;
    logic [RSP_W-1:0]        rsp_packet_q, rsp_packet_d;
    logic                    overflow_q, overflow_d;
    logic                    sleep_ack_q, sleep_ack_d;
    logic                    sleep_status_q, sleep_status_d;

    logic                    w_head_wr;
    logic                    w_head_vld;
    logic [ADDR_WIDTH-1:0]   w_head_addr;
    logic [DATA_WIDTH-1:0]   w_head_data;
    logic                    w_can_issue;
    logic                    w_slot_free;
    logic                    w_accept;
    logic [CNT_WIDTH:0]      w_committed;
    logic                    w_rd_ok;
    logic                    w_cmd;
    logic                    w_cnt_nz;
    logic                    w_rd_rsp;
    logic                    w_timeout;
    logic                    w_inc;
    logic                    w_dec;
    logic                    w_drained;
    logic                    w_sleep_any;

    assign w_head_wr   = i_req_packet[REQ_W-1];
    assign w_head_vld  = i_req_packet[REQ_W-2];
    assign w_head_addr = i_req_packet[DATA_WIDTH +: ADDR_WIDTH];
    assign w_head_data = i_req_packet[DATA_WIDTH-1:0];

    assign w_can_issue = (state_q == ST_NORMAL) || (state_q == ST_DRAIN);
    assign w_slot_free = !valid_q || i_ready;
    assign w_accept    = valid_q && i_ready;

    // A read waiting in the command register is already committed, so it
    // counts against the in-flight limit before the master accepts it.
    assign w_committed = {1'b0, outstanding_q}
                       + {{CNT_WIDTH{1'b0}}, (valid_q && !rd0_wr1_q)};
    assign w_rd_ok     = (w_committed < c_max) && !i_rsp_fifo_full;

    // The pop strobe is combinational, so it is gated by reset explicitly.
    assign w_cmd = i_rstn_sink && w_can_issue && !i_req_fifo_empty
                && w_slot_free && (w_head_wr || w_rd_ok);

    assign w_cnt_nz  = |outstanding_q;
    assign w_rd_rsp  = i_rd_valid && w_cnt_nz;
    assign w_timeout = w_cnt_nz && !i_rd_valid && (tmr_q == c_tmr_last);
    assign w_inc     = w_accept && !rd0_wr1_q;
    assign w_dec     = w_rd_rsp || w_timeout;

    assign w_sleep_any = i_sink_sleep_req || i_source_sleep_status;
    assign w_drained   = i_req_fifo_empty && i_rsp_fifo_empty && !w_cnt_nz
                      && !valid_q && i_source_sleep_status;

    always_comb begin
        valid_d       = valid_q;
        rd0_wr1_d     = rd0_wr1_q;
        addr_d        = addr_q;
        wr_data_d     = wr_data_q;
        outstanding_d = outstanding_q;
        tmr_d         = tmr_q;
        rsp_wr_en_d   = 1'b0;
        rsp_packet_d  = rsp_packet_q;
        overflow_d    = overflow_q;

        if (w_cmd && w_head_vld) begin
            valid_d   = 1'b1;
            rd0_wr1_d = w_head_wr;
            addr_d    = w_head_addr;
            wr_data_d = w_head_data;
        end else if (w_accept) begin
            valid_d = 1'b0;
        end

        if (w_inc && !w_dec) begin
            outstanding_d = outstanding_q + CNT_WIDTH'(1);
        end else if (!w_inc && w_dec) begin
            outstanding_d = outstanding_q - CNT_WIDTH'(1);
        end

        if (!w_cnt_nz || i_rd_valid || w_timeout) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + c_tmr_w'(1);
        end

        // A response that finds the FIFO full is lost; record it stickily.
        if (w_dec) begin
            rsp_packet_d = w_rd_rsp ? {1'b0, 1'b1, i_rd_data}
                                    : {1'b1, 1'b1, {DATA_WIDTH{1'b0}}};
            if (i_rsp_fifo_full) begin
                overflow_d = 1'b1;
            end else begin
                rsp_wr_en_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: begin
                if (w_sleep_any) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_sleep_any) begin
                    state_d = ST_NORMAL;
                end else if (w_drained) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!w_sleep_any) begin
                    state_d = ST_WAKE;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase

        sleep_status_d = (state_d == ST_IDLE);
        sleep_ack_d    = (state_d == ST_IDLE) && i_sink_sleep_req;
    end

    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            state_q        <= ST_NORMAL;
            valid_q        <= 1'b0;
            rd0_wr1_q      <= 1'b0;
            addr_q         <= '0;
            wr_data_q      <= '0;
            outstanding_q  <= '0;
            tmr_q          <= '0;
            rsp_wr_en_q    <= 1'b0;
            rsp_packet_q   <= '0;
            overflow_q     <= 1'b0;
            sleep_ack_q    <= 1'b0;
            sleep_status_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            rd0_wr1_q      <= rd0_wr1_d;
            addr_q         <= addr_d;
            wr_data_q      <= wr_data_d;
            outstanding_q  <= outstanding_d;
            tmr_q          <= tmr_d;
            rsp_wr_en_q    <= rsp_wr_en_d;
            rsp_packet_q   <= rsp_packet_d;
            overflow_q     <= overflow_d;
            sleep_ack_q    <= sleep_ack_d;
            sleep_status_q <= sleep_status_d;
        end
    end

    assign o_req_fifo_rd_en    = w_cmd;
    assign o_rsp_fifo_wr_en    = rsp_wr_en_q;
    assign o_rsp_packet        = rsp_packet_q;
    assign o_valid             = valid_q;
    assign o_rd0_wr1           = rd0_wr1_q;
    assign o_addr              = addr_q;
    assign o_wr_data           = wr_data_q;
    assign o_sink_sleep_ack    = sleep_ack_q;
    assign o_sink_sleep_status = sleep_status_q;
    assign o_outstanding       = outstanding_q;
    assign o_overflow          = overflow_q;

endmodule
`default_nettype wire
